display_arbiter: RTL and testbench
==================================

# display_arbiter

Display-content controller for the 4-digit seven-segment driver. Selects what the driver shows on D3..D0 among three sources: a persistent balance/time value, transient messages held for a fixed time, and an error indication, which blinks by default. It sits between the charger control logic and the display driver. Its registered D3..D0 outputs connect directly to the driver's digit inputs.

## Interface
Parameters:
- HOLD_CYCLES, 1000: clock cycles a transient message stays displayed (1 s at the 1 ms system clock); must be ≥1.
- BLINK_HALF, 250: cycles per blink half-period in error state; must be ≥1.
- BLANK, 4'hF: digit code the driver renders as all segments off.
- ERR_GLYPH, 4'hE: digit code the driver renders as "E".

Ports:
- CLK  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- bal_val  in  16  steady source: four BCD digits {D3,D2,D1,D0}.
- msg_vld  in  1  transient message request, sampled each cycle.
- msg_val  in  16  message digits, valid while msg_vld=1.
- msg_ack  out  1  one-cycle pulse: message latched.
- err_set  in  1  level: error condition present.
- err_code  in  4  error number shown on D0 in error state.
- D3, D2, D1, D0  out  4 each  registered digit codes to display driver.
- mode  out  2  current state: 0 IDLE, 1 MSG, 2 ERR.

## Operation
- States: IDLE (show balance), MSG (show latched message), ERR (show error).
- Priority per cycle: err_set > msg_vld > hold timeout.
- IDLE:
  - err_set=1 -> ERR.
  - else msg_vld=1 -> latch msg_val, pulse msg_ack, load hold counter with HOLD_CYCLES-1, -> MSG.
- MSG:
  - err_set=1 -> ERR; message discarded.
  - else msg_vld=1 -> re-latch, msg_ack pulse, reload counter; stay in MSG.
  - else counter==0 -> IDLE; else decrement.
- ERR:
  - err_set=0 -> IDLE; blink state cleared.
  - msg_vld is ignored: no latch, no ack.
- IDLE display: bal_val with leading-zero suppression. From D3 downward, digits equal to 0 are replaced by BLANK until the first nonzero digit. D0 is never suppressed. Non-BCD codes (>9) pass unchanged and stop suppression.
- MSG display: latched msg_val verbatim, no suppression.
- ERR display (visible phase): {ERR_GLYPH, BLANK, BLANK, err_code}; err_code is tracked live.
- Hold counter width: $clog2(HOLD_CYCLES+1). Blink counter width: $clog2(BLINK_HALF+1). No wrap beyond terminal count: counters reload, never underflow.

## Timing
- Reset (rst=0, async): D3..D0=BLANK, mode=0, msg_ack=0, counters=0, blink phase=visible.
- Latency: one cycle from input sample to D3..D0/mode/msg_ack update.
  - Example: msg_vld high at edge N gives mode=1, msg_ack=1 and message on D after edge N.
- With one msg_vld pulse, the message is displayed exactly HOLD_CYCLES cycles, then balance appears.
- msg_vld held high continuously: re-latched and acked every cycle, so the display tracks msg_val.
- err_set and msg_vld in the same cycle: ERR entered, msg_ack stays 0.
- rst asserted mid-MSG or mid-ERR: immediate return to reset values; no pending message survives.

## Configuration
- DISP_BLINK_EN:
  - Defined: in ERR, visible pattern for BLINK_HALF cycles, then all four digits BLANK for BLINK_HALF cycles, repeating. Visible phase starts on the first ERR cycle.
  - Undefined: ERR pattern shown steadily and the blink counter is not synthesized.
- Defined by default in the project build.

## Test plan
- Reset, then bal_val=16'h0205 -> D3..D0 = F,2,0,5; mode=0; msg_ack=0.
- bal_val=16'h0007 -> D = F,F,F,7. bal_val=16'h0000 -> D = F,F,F,0.
- HOLD_CYCLES=4, one-cycle msg_vld with msg_val=16'h1234 -> msg_ack=1 for 1 cycle; D=1,2,3,4 for exactly 4 cycles; then balance.
- In MSG, second msg_vld with 16'h5678 two cycles later -> new ack; D=5,6,7,8; hold restarts from 4.
- err_set=1 with err_code=3 and msg_vld simultaneously:
  - Response: mode=2, no ack, D=E,F,F,3.
  - DISP_BLINK_EN with BLINK_HALF=2: pattern 2 cycles, then F,F,F,F 2 cycles.
  - err_set=0 -> IDLE next cycle.
- rst pulsed low mid-MSG (asynchronous, not clock-aligned) -> D=F,F,F,F and mode=0 immediately; after release, balance shown with no message.

Source files
------------

// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - source/handshake and digit bus between charger logic, arbiter and display driver
interface display_arbiter_if;
    logic [15:0] bal_val;
    logic        msg_vld;
    logic [15:0] msg_val;
    logic        msg_ack;
    logic        err_set;
    logic [3:0]  err_code;
    logic [3:0]  D3;
    logic [3:0]  D2;
    logic [3:0]  D1;
    logic [3:0]  D0;
    logic [1:0]  mode;

    modport master (
        output bal_val, msg_vld, msg_val, err_set, err_code,
        input  msg_ack, D3, D2, D1, D0, mode
    );

    modport slave (
        input  bal_val, msg_vld, msg_val, err_set, err_code,
        output msg_ack, D3, D2, D1, D0, mode
    );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - chooses balance, held message or error pattern for the 4-digit display
// Optional macro DISP_BLINK_EN: blink the error pattern with BLINK_HALF-cycle half-periods.
module display_arbiter #(
    parameter int         HOLD_CYCLES = 1000,
    parameter int         BLINK_HALF  = 250,
    parameter logic [3:0] BLANK       = 4'hF,
    parameter logic [3:0] ERR_GLYPH   = 4'hE
) (
    input  logic              CLK,
    input  logic              rst,
    display_arbiter_if.slave  bus
);
    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   msg_q, msg_n;
    logic [15:0]   d_q, d_n;
    logic [HW-1:0] hold_q, hold_n;
    logic          ack_q, ack_n;
    logic          blink_vis_n;

    // Leading zeros become blank down to D1; a non-BCD code counts as significant.
    function automatic logic [15:0] suppress(input logic [15:0] v);
        logic [15:0] r;
        logic        lead;
        r    = v;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && v[i*4 +: 4] == 4'd0) begin
                r[i*4 +: 4] = BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

`ifdef DISP_BLINK_EN
    localparam int            BW         = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_q, blink_n;
    logic          vis_q;

    always_comb begin
        blink_n     = '0;
        blink_vis_n = 1'b1;
        if (state_n == ERR) begin
            if (state != ERR) begin
                blink_n     = BLINK_LOAD;
                blink_vis_n = 1'b1;
            end else if (blink_q == '0) begin
                blink_n     = BLINK_LOAD;
                blink_vis_n = ~vis_q;
            end else begin
                blink_n     = blink_q - BW'(1);
                blink_vis_n = vis_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
            vis_q   <= 1'b1;
        end else begin
            blink_q <= blink_n;
            vis_q   <= blink_vis_n;
        end
    end
`else
    assign blink_vis_n = 1'b1;
`endif

    always_comb begin
        state_n = state;
        msg_n   = msg_q;
        hold_n  = hold_q;
        ack_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.err_set) begin
                    state_n = ERR;
                end else if (bus.msg_vld) begin
                    msg_n   = bus.msg_val;
                    ack_n   = 1'b1;
                    hold_n  = HOLD_LOAD;
                    state_n = MSG;
                end
            end
            MSG: begin
                if (bus.err_set) begin
                    msg_n   = '0;
                    hold_n  = '0;
                    state_n = ERR;
                end else if (bus.msg_vld) begin
                    msg_n  = bus.msg_val;
                    ack_n  = 1'b1;
                    hold_n = HOLD_LOAD;
                end else if (hold_q == '0) begin
                    state_n = IDLE;
                end else begin
                    hold_n = hold_q - HW'(1);
                end
            end
            ERR: begin
                if (!bus.err_set) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        d_n = {4{BLANK}};
        case (state_n)
            IDLE:    d_n = suppress(bus.bal_val);
            MSG:     d_n = msg_n;
            ERR:     d_n = blink_vis_n ? {ERR_GLYPH, BLANK, BLANK, bus.err_code} : {4{BLANK}};
            default: d_n = {4{BLANK}};
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            msg_q  <= '0;
            hold_q <= '0;
            ack_q  <= 1'b0;
            d_q    <= {4{BLANK}};
        end else begin
            state  <= state_n;
            msg_q  <= msg_n;
            hold_q <= hold_n;
            ack_q  <= ack_n;
            d_q    <= d_n;
        end
    end

    assign bus.D3      = d_q[15:12];
    assign bus.D2      = d_q[11:8];
    assign bus.D1      = d_q[7:4];
    assign bus.D0      = d_q[3:0];
    assign bus.mode    = state;
    assign bus.msg_ack = ack_q;
endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - scoreboard bench for display_arbiter (HOLD_CYCLES=4, BLINK_HALF=2)
module tb_display_arbiter;
    logic CLK = 1'b0;
    logic rst = 1'b1;

    display_arbiter_if bus ();

    display_arbiter #(
        .HOLD_CYCLES(4),
        .BLINK_HALF (2),
        .BLANK      (4'hF),
        .ERR_GLYPH  (4'hE)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

`ifdef DISP_BLINK_EN
    localparam logic [15:0] OFF3 = 16'hFFFF;
`else
    localparam logic [15:0] OFF3 = 16'hEFF3;
`endif

    typedef struct {
        int          id;
        logic [15:0] d;
        logic [1:0]  m;
        logic        a;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic check_now(input string name, input logic [15:0] ed, input logic [1:0] em, input logic ea);
        logic [15:0] ad;
        ad = {bus.D3, bus.D2, bus.D1, bus.D0};
        checks++;
        if (ad !== ed || bus.mode !== em || bus.msg_ack !== ea) begin
            errors++;
            $display("FAIL %s: got D=%h mode=%0d ack=%b, expected D=%h mode=%0d ack=%b",
                     name, ad, bus.mode, bus.msg_ack, ed, em, ea);
        end
    endtask

    task automatic step(input logic [15:0] bal, input logic vld, input logic [15:0] val,
                        input logic err, input logic [3:0] code,
                        input logic [15:0] ed, input logic [1:0] em, input logic ea);
        exp_t e;
        @(negedge CLK);
        rst          = 1'b1;
        bus.bal_val  = bal;
        bus.msg_vld  = vld;
        bus.msg_val  = val;
        bus.err_set  = err;
        bus.err_code = code;
        step_id++;
        e.id = step_id;
        e.d  = ed;
        e.m  = em;
        e.a  = ea;
        q.push_back(e);
    endtask

    always @(posedge CLK) begin
        exp_t   e;
        logic [15:0] ad;
        #1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            ad = {bus.D3, bus.D2, bus.D1, bus.D0};
            checks++;
            if (ad !== e.d || bus.mode !== e.m || bus.msg_ack !== e.a) begin
                errors++;
                $display("FAIL step%0d: got D=%h mode=%0d ack=%b, expected D=%h mode=%0d ack=%b",
                         e.id, ad, bus.mode, bus.msg_ack, e.d, e.m, e.a);
            end
        end
    end

    initial begin
        exp_t e;
        bus.bal_val  = 16'h0;
        bus.msg_vld  = 1'b0;
        bus.msg_val  = 16'h0;
        bus.err_set  = 1'b0;
        bus.err_code = 4'h0;
        #1 rst = 1'b0;
        #1 check_now("reset_state", 16'hFFFF, 2'd0, 1'b0);

        // leading-zero suppression
        step(16'h0205, 0, 16'h0, 0, 4'h0, 16'hF205, 2'd0, 1'b0);
        step(16'h0007, 0, 16'h0, 0, 4'h0, 16'hFFF7, 2'd0, 1'b0);
        step(16'h0000, 0, 16'h0, 0, 4'h0, 16'hFFF0, 2'd0, 1'b0);
        step(16'h0A05, 0, 16'h0, 0, 4'h0, 16'hFA05, 2'd0, 1'b0);
        step(16'h3000, 0, 16'h0, 0, 4'h0, 16'h3000, 2'd0, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);

        // single message held exactly 4 cycles
        step(16'h0042, 1, 16'h1234, 0, 4'h0, 16'h1234, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0042, 0, 16'h0, 0, 4'h0, 16'h1234, 2'd1, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);

        // re-latch two cycles in restarts the hold
        step(16'h0042, 1, 16'h1234, 0, 4'h0, 16'h1234, 2'd1, 1'b1);
        step(16'h0042, 0, 16'h0,    0, 4'h0, 16'h1234, 2'd1, 1'b0);
        step(16'h0042, 1, 16'h5678, 0, 4'h0, 16'h5678, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0042, 0, 16'h0, 0, 4'h0, 16'h5678, 2'd1, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);

        // continuous msg_vld tracks msg_val
        step(16'h0042, 1, 16'h1111, 0, 4'h0, 16'h1111, 2'd1, 1'b1);
        step(16'h0042, 1, 16'h2222, 0, 4'h0, 16'h2222, 2'd1, 1'b1);
        step(16'h0042, 1, 16'h3333, 0, 4'h0, 16'h3333, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0042, 0, 16'h0, 0, 4'h0, 16'h3333, 2'd1, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);

        // error beats simultaneous message; msg_vld ignored in ERR
        step(16'h0042, 1, 16'h9999, 1, 4'h3, 16'hEFF3, 2'd2, 1'b0);
        step(16'h0042, 1, 16'h9999, 1, 4'h3, 16'hEFF3, 2'd2, 1'b0);
        step(16'h0042, 1, 16'h9999, 1, 4'h3, OFF3,     2'd2, 1'b0);
        step(16'h0042, 1, 16'h9999, 1, 4'h3, OFF3,     2'd2, 1'b0);
        step(16'h0042, 1, 16'h9999, 1, 4'h7, 16'hEFF7, 2'd2, 1'b0);
        step(16'h0042, 0, 16'h0,    1, 4'h7, 16'hEFF7, 2'd2, 1'b0);
        step(16'h0042, 0, 16'h0,    0, 4'h7, 16'hFF42, 2'd0, 1'b0);
        step(16'h0042, 0, 16'h0,    0, 4'h7, 16'hFF42, 2'd0, 1'b0);

        // error from MSG discards message; blink restarts visible
        step(16'h0042, 1, 16'h4321, 0, 4'h1, 16'h4321, 2'd1, 1'b1);
        step(16'h0042, 0, 16'h0,    1, 4'h1, 16'hEFF1, 2'd2, 1'b0);
        step(16'h0042, 0, 16'h0,    0, 4'h1, 16'hFF42, 2'd0, 1'b0);

        // asynchronous reset mid-MSG
        step(16'h0042, 1, 16'hABCD, 0, 4'h0, 16'hABCD, 2'd1, 1'b1);
        step(16'h0042, 0, 16'h0,    0, 4'h0, 16'hABCD, 2'd1, 1'b0);
        @(negedge CLK);
        bus.msg_vld = 1'b0;
        step_id++;
        e.id = step_id; e.d = 16'hFFFF; e.m = 2'd0; e.a = 1'b0;
        q.push_back(e);
        #2 rst = 1'b0;
        #1 check_now("async_reset", 16'hFFFF, 2'd0, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);
        step(16'h0042, 0, 16'h0, 0, 4'h0, 16'hFF42, 2'd0, 1'b0);
        step(16'h0109, 0, 16'h0, 0, 4'h0, 16'hF109, 2'd0, 1'b0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
